// File: rtl/xb_fifo_reader.sv
// Consumer end of the DDR-to-wavelet FIFO: drains whole bursts once they are buffered and
// presents them as a valid/ready sample stream with block start/end markers.
module xb_fifo_reader #(
    parameter int unsigned BURST      = 8,
    parameter int unsigned OBUF_DEPTH = 4,
    parameter int unsigned FRAME_LEN  = 1024
) (
    input  logic        clk_150_90,
    input  logic        reset_syn,
    input  logic [15:0] fifo_xb_r_data,
    input  logic [2:0]  fifo_xb_use,
    input  logic        fifo_xb_full,
    input  logic        fifo_xb_empty,
    output logic        fifo_xb_rreq,
    output logic [15:0] xb_data,
    output logic        xb_valid,
    input  logic        xb_ready,
    output logic        xb_sof,
    output logic        xb_eof,
    output logic [15:0] burst_cnt,
    output logic        underflow_err
);

    localparam int unsigned AW = $clog2(OBUF_DEPTH);
    localparam int unsigned OW = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned FW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [3:0]      r_left;
    logic [3:0]      w_left_d;
    logic            r_rreq;
    logic            r_inflight;
    logic            r_underflow;
    logic [15:0]     r_burst_cnt;
    logic            w_burst_inc;
    logic [15:0]     r_mem [OBUF_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [OW-1:0]   r_occ;
    logic [FW-1:0]   r_frame;

    logic [3:0]      w_avail;
    logic            w_valid;
    logic            w_pop;
    logic [3:0]      w_credit_sum;
    logic            w_credit;
    logic            w_issue;

    // usedw wraps to 0 when the 8-deep FIFO is full, so full stands in for the missing bit.
    assign w_avail      = fifo_xb_full ? 4'd8 : {1'b0, fifo_xb_use};
    assign w_valid      = (r_occ != '0);
    assign w_pop        = w_valid & xb_ready;
    assign w_credit_sum = 4'(r_occ) + 4'(r_inflight) - 4'(w_pop);
    assign w_credit     = (w_credit_sum <= 4'(OBUF_DEPTH - 2));
    assign w_issue      = (r_state == StRead) && (r_left != 4'd0) && w_credit && !fifo_xb_empty;

    always_comb begin
        w_state_d   = r_state;
        w_left_d    = r_left;
        w_burst_inc = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_avail >= 4'(BURST)) begin
                    w_left_d  = 4'(BURST);
                    w_state_d = StRead;
                end
            end
            StRead: begin
                if (w_issue) begin
                    w_left_d = r_left - 4'd1;
                    if (r_left == 4'd1) begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_burst_inc = 1'b1;
                w_state_d   = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_150_90) begin
        if (reset_syn) begin
            r_state     <= StIdle;
            r_left      <= 4'd0;
            r_rreq      <= 1'b0;
            r_inflight  <= 1'b0;
            r_underflow <= 1'b0;
            r_burst_cnt <= 16'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_occ       <= '0;
            r_frame     <= '0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_mem[i] <= 16'd0;
            end
        end else begin
            r_state    <= w_state_d;
            r_left     <= w_left_d;
            r_rreq     <= w_issue;
            // FIFO q is valid the cycle after rreq; capture it then.
            r_inflight <= r_rreq;
            if (r_rreq && fifo_xb_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_burst_inc) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
            if (r_inflight) begin
                r_mem[r_wptr] <= fifo_xb_r_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_frame <= (r_frame == FW'(FRAME_LEN - 1)) ? '0 : r_frame + FW'(1);
            end
            r_occ <= r_occ + OW'(r_inflight) - OW'(w_pop);
        end
    end

    assign fifo_xb_rreq  = r_rreq;
    assign xb_valid      = w_valid;
    assign xb_data       = r_mem[r_rptr];
    assign xb_sof        = w_valid && (r_frame == '0);
    assign xb_eof        = w_valid && (r_frame == FW'(FRAME_LEN - 1));
    assign burst_cnt     = r_burst_cnt;
    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_xb_fifo_reader.sv
// Bench for xb_fifo_reader: behavioural FIFO model feeding the DUT, scoreboard of
// written words checked by a forked monitor, plus directed checks on control behaviour.
module tb_xb_fifo_reader;

    localparam int unsigned FrameLen = 16;

    logic        clk = 1'b0;
    logic        reset_syn;
    logic [15:0] fifo_xb_r_data;
    logic [2:0]  fifo_xb_use;
    logic        fifo_xb_full;
    logic        fifo_xb_empty;
    logic        fifo_xb_rreq;
    logic [15:0] xb_data;
    logic        xb_valid;
    logic        xb_ready;
    logic        xb_sof;
    logic        xb_eof;
    logic [15:0] burst_cnt;
    logic        underflow_err;

    always #5 clk = ~clk;

    xb_fifo_reader #(
        .BURST      (8),
        .OBUF_DEPTH (4),
        .FRAME_LEN  (FrameLen)
    ) dut (
        .clk_150_90     (clk),
        .reset_syn      (reset_syn),
        .fifo_xb_r_data (fifo_xb_r_data),
        .fifo_xb_use    (fifo_xb_use),
        .fifo_xb_full   (fifo_xb_full),
        .fifo_xb_empty  (fifo_xb_empty),
        .fifo_xb_rreq   (fifo_xb_rreq),
        .xb_data        (xb_data),
        .xb_valid       (xb_valid),
        .xb_ready       (xb_ready),
        .xb_sof         (xb_sof),
        .xb_eof         (xb_eof),
        .burst_cnt      (burst_cnt),
        .underflow_err  (underflow_err)
    );

    // FIFO model: 8 x 16, q registered one cycle after rreq.
    logic [15:0] f_mem [8];
    logic [2:0]  f_wp;
    logic [2:0]  f_rp;
    logic [3:0]  f_cnt;
    logic        f_rd;
    logic        f_wr;
    logic        f_clr;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        ovr_en;
    logic [2:0]  ovr_use;
    logic        ovr_full;
    logic        force_empty;

    assign f_rd          = fifo_xb_rreq && (f_cnt != 4'd0);
    assign f_wr          = wr_en && (f_cnt != 4'd8);
    assign fifo_xb_use   = ovr_en ? ovr_use : f_cnt[2:0];
    assign fifo_xb_full  = ovr_en ? ovr_full : (f_cnt == 4'd8);
    assign fifo_xb_empty = force_empty | (f_cnt == 4'd0);

    always @(posedge clk) begin
        if (f_clr) begin
            f_wp           <= 3'd0;
            f_rp           <= 3'd0;
            f_cnt          <= 4'd0;
            fifo_xb_r_data <= 16'd0;
        end else begin
            if (f_wr) begin
                f_mem[f_wp] <= wr_data;
                f_wp        <= f_wp + 3'd1;
            end
            if (f_rd) begin
                fifo_xb_r_data <= f_mem[f_rp];
                f_rp           <= f_rp + 3'd1;
            end
            f_cnt <= f_cnt + {3'b0, f_wr} - {3'b0, f_rd};
        end
    end

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    exp_t exp_q[$];
    int   idx;
    int   n_vec;
    int   n_err;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pops one expectation per accepted sample; a sample taken on a reset edge is discarded.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset_syn && xb_valid && xb_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_sample: got data=%h with nothing expected", xb_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({xb_data, xb_sof, xb_eof} !== {e.data, e.sof, e.eof}) begin
                        n_err++;
                        $display("FAIL sample: got data=%h sof=%b eof=%b, expected data=%h sof=%b eof=%b",
                                 xb_data, xb_sof, xb_eof, e.data, e.sof, e.eof);
                    end
                end
            end
        end
    endtask

    task automatic write_words(input logic [15:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            for (int w = 0; w < 200 && f_cnt == 4'd8; w++) begin
                tick();
            end
            if (f_cnt == 4'd8) begin
                $display("FAIL fifo_room_timeout: got full, expected room");
                n_vec++;
                n_err++;
            end
            wr_en   = 1'b1;
            wr_data = base + 16'(i);
            e.data  = wr_data;
            e.sof   = (idx % FrameLen) == 0;
            e.eof   = (idx % FrameLen) == FrameLen - 1;
            exp_q.push_back(e);
            idx++;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run(input int n, output int nr, output int nv);
        nr = 0;
        nv = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (fifo_xb_rreq) nr++;
            if (xb_valid) nv++;
        end
    endtask

    task automatic assert_reset();
        reset_syn = 1'b1;
        exp_q.delete();
        idx = 0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rreq"}, 32'(fifo_xb_rreq), 0);
        check({tag, "_valid"}, 32'(xb_valid), 0);
        check({tag, "_data"}, 32'(xb_data), 0);
        check({tag, "_sof"}, 32'(xb_sof), 0);
        check({tag, "_eof"}, 32'(xb_eof), 0);
        check({tag, "_burst_cnt"}, 32'(burst_cnt), 0);
        check({tag, "_underflow"}, 32'(underflow_err), 0);
    endtask

    initial begin
        int nr;
        int nv;
        int first_r;
        int last_r;
        int first_v;
        int last_v;
        int seen;
        logic found;

        reset_syn   = 1'b1;
        f_clr       = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 16'd0;
        xb_ready    = 1'b1;
        ovr_en      = 1'b0;
        ovr_use     = 3'd0;
        ovr_full    = 1'b0;
        force_empty = 1'b0;
        idx         = 0;
        n_vec       = 0;
        n_err       = 0;

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        tick();
        tick();
        f_clr = 1'b0;
        check_all_zero("reset");

        // Test 1: FIFO preloaded full while held in reset, then released.
        write_words(16'h0001, 8);
        reset_syn = 1'b0;
        first_r = -1; last_r = -1; first_v = -1; last_v = -1; nr = 0; nv = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (fifo_xb_rreq) begin
                if (first_r < 0) first_r = i;
                last_r = i;
                nr++;
            end
            if (xb_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nv++;
            end
        end
        // Edge 0: IDLE->READ, edge 1: rreq, edge 2: FIFO q, edge 3: captured.
        check("t1_first_rreq", 32'(first_r), 1);
        check("t1_last_rreq", 32'(last_r), 8);
        check("t1_rreq_count", 32'(nr), 8);
        check("t1_first_valid", 32'(first_v), 3);
        check("t1_last_valid", 32'(last_v), 10);
        check("t1_valid_count", 32'(nv), 8);
        check("t1_burst_cnt", 32'(burst_cnt), 1);

        // Test 2: seven words never start a burst; the eighth does.
        write_words(16'h0101, 7);
        run(50, nr, nv);
        check("t2_idle_rreq", 32'(nr), 0);
        check("t2_idle_valid", 32'(nv), 0);
        write_words(16'h0108, 1);
        tick();
        check("t2_rreq_not_yet", 32'(fifo_xb_rreq), 0);
        tick();
        check("t2_rreq_started", 32'(fifo_xb_rreq), 1);
        run(20, nr, nv);
        check("t2_burst_cnt", 32'(burst_cnt), 2);

        // Test 3: consumer stalled; credit limits reads to the buffer depth.
        xb_ready = 1'b0;
        write_words(16'h0201, 8);
        run(30, nr, nv);
        check("t3_stalled_reads", 32'(nr), 4);
        check("t3_held_valid", 32'(xb_valid), 1);
        check("t3_held_data", 32'(xb_data), 32'h0201);
        check("t3_held_sof", 32'(xb_sof), 1);
        xb_ready = 1'b1;
        run(30, nr, nv);
        check("t3_resume_reads", 32'(nr), 4);
        check("t3_burst_cnt", 32'(burst_cnt), 3);
        check("t3_drained", 32'(exp_q.size()), 0);

        // Test 4: 32-sample ramp across two 16-sample frames.
        assert_reset();
        reset_syn = 1'b0;
        write_words(16'h0000, 32);
        run(30, nr, nv);
        check("t4_burst_cnt", 32'(burst_cnt), 4);
        check("t4_drained", 32'(exp_q.size()), 0);

        // Test 5: reset one cycle after the third rreq of a burst.
        assert_reset();
        reset_syn = 1'b0;
        write_words(16'h0401, 8);
        seen = 0;
        for (int i = 0; i < 30 && seen < 3; i++) begin
            tick();
            if (fifo_xb_rreq) seen++;
        end
        check("t5_third_rreq", 32'(seen), 3);
        tick();
        assert_reset();
        reset_syn = 1'b0;
        check_all_zero("t5_after_reset");
        run(15, nr, nv);
        check("t5_no_stale_valid", 32'(nv), 0);
        check("t5_no_rreq", 32'(nr), 0);
        f_clr = 1'b1;
        tick();
        f_clr = 1'b0;

        // Test 6a: stale avail says full but empty is asserted; no read may issue.
        ovr_en      = 1'b1;
        ovr_use     = 3'd0;
        ovr_full    = 1'b1;
        force_empty = 1'b1;
        write_words(16'h0501, 8);
        run(10, nr, nv);
        check("t6a_no_rreq", 32'(nr), 0);
        check("t6a_no_underflow", 32'(underflow_err), 0);
        ovr_en      = 1'b0;
        force_empty = 1'b0;
        run(25, nr, nv);
        check("t6a_reads", 32'(nr), 8);
        check("t6a_burst_cnt", 32'(burst_cnt), 1);
        check("t6a_drained", 32'(exp_q.size()), 0);

        // Test 6b: empty forced during a cycle with rreq high.
        write_words(16'h0601, 8);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (fifo_xb_rreq) found = 1'b1;
        end
        check("t6b_rreq_seen", 32'(found), 1);
        force_empty = 1'b1;
        tick();
        force_empty = 1'b0;
        check("t6b_underflow_set", 32'(underflow_err), 1);
        run(25, nr, nv);
        check("t6b_underflow_sticky", 32'(underflow_err), 1);
        check("t6b_burst_cnt", 32'(burst_cnt), 2);
        check("t6b_drained", 32'(exp_q.size()), 0);
        assert_reset();
        reset_syn = 1'b0;
        check("t6b_underflow_cleared", 32'(underflow_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
